// File: rtl/ir_encoder_pkg.sv
// ---------------------------------------------------------------------------
// ir_encoder_pkg
//   Shared definitions for the instruction encoder slice.
//   - fmt_e        : instruction format selector (REG / IMM / JMP / reserved)
//   - state_e      : load-session state, also visible on ir_encoder.state_o
//   - ir_fields_t  : the raw instruction fields presented on the input side
//   - JMP_OP_PREFIX: opcode bits [3:1] every legal jump must carry
//   - field_illegal: the single place that decides whether a field set is
//                    an illegal encoding
// ---------------------------------------------------------------------------
package ir_encoder_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        FMT_REG = 2'd0,
        FMT_IMM = 2'd1,
        FMT_JMP = 2'd2,
        FMT_RSV = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    // Jumps only exist as op_code 4'b100x; bit 0 is carried into the word.
    localparam logic [2:0] JMP_OP_PREFIX = 3'b100;

    typedef struct packed {
        fmt_e       fmt;
        logic [3:0] op_code;
        logic [2:0] subop_code;
        logic       skip_bit;
        logic [3:0] sel_ra;
        logic [3:0] sel_rb;
        logic [7:0] imm;
        logic [9:0] addr;
    } ir_fields_t;

    // REG/IMM own the lower half of the opcode space; the upper half is
    // reserved for jumps, and only the JMP_OP_PREFIX pair is defined there.
    function automatic logic field_illegal(input fmt_e fmt, input logic [3:0] op_code);
        logic bad;
        bad = 1'b0;
        case (fmt)
            FMT_REG: bad = op_code[3];
            FMT_IMM: bad = op_code[3];
            FMT_JMP: bad = (op_code[3:1] != JMP_OP_PREFIX);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ir_encoder_pack.sv
// ---------------------------------------------------------------------------
// ir_pack
//   Purely combinational field-to-word packer.
//   Ports:
//     fields  in  ir_fields_t  raw instruction fields
//     word    out 16           encoded instruction word (0 when illegal)
//     illegal out 1            field set does not form a legal encoding
//   Layouts:
//     REG: op[15:12] subop[11:9] skip[8] rb[7:4] ra[3:0]
//     IMM: op[15:12] imm[11:4] ra[3:0]
//     JMP: 1[15] op[0][14] addr[13:4] 0[3:0]
// ---------------------------------------------------------------------------
module ir_pack
    import ir_encoder_pkg::*;
(
    input  ir_fields_t          fields,
    output logic [WORD_W-1:0]   word,
    output logic                illegal
);

    logic [WORD_W-1:0] raw_word;

    always_comb begin
        raw_word = '0;
        case (fields.fmt)
            FMT_REG: raw_word = {fields.op_code, fields.subop_code, fields.skip_bit,
                                 fields.sel_rb, fields.sel_ra};
            FMT_IMM: raw_word = {fields.op_code, fields.imm, fields.sel_ra};
            FMT_JMP: raw_word = {1'b1, fields.op_code[0], fields.addr, 4'b0000};
            default: raw_word = '0;
        endcase
    end

    // The word is never written when illegal; forcing it to zero keeps the
    // output stage from latching meaningless bits into mem_wdata.
    always_comb begin
        illegal = field_illegal(fields.fmt, fields.op_code);
        word    = illegal ? '0 : raw_word;
    end

endmodule

// File: rtl/ir_encoder.sv
// ---------------------------------------------------------------------------
// ir_encoder
//   Accepts instruction fields over a valid/ready handshake, packs them into
//   16-bit words and streams them into program memory starting at the
//   session's base address.
//
//   Handshakes:
//     in_valid/in_ready : a field set is consumed on a rising edge where both
//                         are high. in_valid may be held; fields must be
//                         stable while in_valid=1 and in_ready=0.
//     mem_we/mem_ready  : a write completes on a rising edge where both are
//                         high. mem_we, mem_addr and mem_wdata hold while
//                         mem_we=1 and mem_ready=0.
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     start           begin a load session (any state), samples base_addr
//     base_addr       first write address of the session
//     in_valid/ready  field handshake (see above)
//     fmt, op_code, subop_code, skip_bit, sel_ra, sel_rb, imm, addr
//                     instruction fields
//     mem_we/ready    memory write handshake (see above)
//     mem_addr        write address; also the next free address when idle
//     mem_wdata       encoded word
//     count           words written in the current session
//     err_illegal     sticky: an illegal field set was consumed this session
//     state_o         IDLE=0, LOAD=1, FULL=2
// ---------------------------------------------------------------------------
module ir_encoder
    import ir_encoder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          fmt,
    input  logic [3:0]          op_code,
    input  logic [2:0]          subop_code,
    input  logic                skip_bit,
    input  logic [3:0]          sel_ra,
    input  logic [3:0]          sel_rb,
    input  logic [7:0]          imm,
    input  logic [9:0]          addr,
    output logic                mem_we,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    output logic [ADDR_W:0]     count,
    output logic                err_illegal,
    output logic [1:0]          state_o
);

    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_e             state;
    ir_fields_t         fields;
    logic [WORD_W-1:0]  packed_word;
    logic               word_illegal;
    logic               wr_done;
    logic               accept;
    logic               at_max;

    always_comb begin
        fields            = '0;
        fields.fmt        = fmt_e'(fmt);
        fields.op_code    = op_code;
        fields.subop_code = subop_code;
        fields.skip_bit   = skip_bit;
        fields.sel_ra     = sel_ra;
        fields.sel_rb     = sel_rb;
        fields.imm        = imm;
        fields.addr       = addr;
    end

    ir_pack u_pack (
        .fields  (fields),
        .word    (packed_word),
        .illegal (word_illegal)
    );

    assign wr_done = mem_we && mem_ready;
    assign at_max  = (mem_addr == ADDR_MAX);

    // The output stage is one entry deep, so a new word can enter only when
    // the stage is empty or draining this cycle. When the pending word sits
    // at the last address there is nowhere for a follow-on word to go, so
    // input is refused even though the stage is draining.
    assign in_ready = (state == ST_LOAD) && !start
                   && (!mem_we || mem_ready)
                   && !(mem_we && at_max);

    assign accept  = in_valid && in_ready;
    assign state_o = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
        end else if (start) begin
            // A new session abandons whatever was waiting in the output stage.
            state       <= ST_LOAD;
            mem_we      <= 1'b0;
            mem_addr    <= base_addr;
            count       <= '0;
            err_illegal <= 1'b0;
        end else begin
            if (wr_done) begin
                count <= count + COUNT_ONE;
                // mem_addr parks on the last address rather than wrapping;
                // the session is then full and only start reopens it.
                if (at_max) begin
                    state <= ST_FULL;
                end else begin
                    mem_addr <= mem_addr + ADDR_ONE;
                end
            end

            if (accept && !word_illegal) begin
                mem_we    <= 1'b1;
                mem_wdata <= packed_word;
            end else if (wr_done) begin
                mem_we    <= 1'b0;
            end

            if (accept && word_illegal) begin
                err_illegal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ir_encoder.sv
// ---------------------------------------------------------------------------
// tb_ir_encoder
//   Self-checking bench for ir_encoder: directed scenarios followed by
//   randomized sessions, with expected memory writes queued at accept time
//   and compared by an independent write monitor.
// ---------------------------------------------------------------------------
module tb_ir_encoder;

    localparam int ADDR_W   = 10;
    localparam int MAX_ADDR = (1 << ADDR_W) - 1;
    localparam int EW       = ADDR_W + 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [3:0]        op_code;
    logic [2:0]        subop_code;
    logic              skip_bit;
    logic [3:0]        sel_ra;
    logic [3:0]        sel_rb;
    logic [7:0]        imm;
    logic [9:0]        addr;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              err_illegal;
    logic [1:0]        state_o;

    ir_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .fmt         (fmt),
        .op_code     (op_code),
        .subop_code  (subop_code),
        .skip_bit    (skip_bit),
        .sel_ra      (sel_ra),
        .sel_rb      (sel_rb),
        .imm         (imm),
        .addr        (addr),
        .mem_we      (mem_we),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .count       (count),
        .err_illegal (err_illegal),
        .state_o     (state_o)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Word value built arithmetically from the field weights of each layout.
    function automatic logic [15:0] ref_word(input int f, input int op, input int subop,
                                             input int skip, input int ra, input int rb,
                                             input int im, input int ad);
        int w;
        case (f)
            0:       w = op * 4096 + subop * 512 + skip * 256 + rb * 16 + ra;
            1:       w = op * 4096 + im * 16 + ra;
            2:       w = 32768 + (op % 2) * 16384 + ad * 16;
            default: w = 0;
        endcase
        return 16'(w);
    endfunction

    function automatic bit ref_illegal(input int f, input int op);
        if (f == 3) return 1'b1;
        if (f == 2) return (op / 2) != 4;
        return op >= 8;
    endfunction

    int m_base  = 0;
    int m_addr  = 0;
    int m_legal = 0;
    bit m_err   = 1'b0;
    logic [EW-1:0] exp_q[$];

    // ---------------- mem_ready driver ----------------
    // 0: always ready, 1: random back-pressure, 2: stalled
    int ready_mode = 0;
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = ($urandom_range(0, 3) != 0);
                default: mem_ready = 1'b0;
            endcase
        end
    end

    // ---------------- write monitor / scoreboard ----------------
    bit                stall_prev = 1'b0;
    logic [ADDR_W-1:0] hold_addr;
    logic [15:0]       hold_data;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (stall_prev) begin
            check("stall_we_held", 32'(mem_we), 32'd1);
            check("stall_addr_held", 32'(mem_addr), 32'(hold_addr));
            check("stall_data_held", 32'(mem_wdata), 32'(hold_data));
        end
        if (!rst && !start && mem_we && mem_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e[EW-1:16]));
                check("wr_data", 32'(mem_wdata), 32'(e[15:0]));
            end
        end
        stall_prev = !rst && !start && mem_we && !mem_ready;
        hold_addr  = mem_addr;
        hold_data  = mem_wdata;
    end

    // ---------------- driver tasks ----------------
    // All tasks are entered and left just after a rising edge.
    task automatic set_fields(input int f, input int op, input int subop, input int skip,
                              input int ra, input int rb, input int im, input int ad);
        fmt        = f[1:0];
        op_code    = op[3:0];
        subop_code = subop[2:0];
        skip_bit   = skip[0];
        sel_ra     = ra[3:0];
        sel_rb     = rb[3:0];
        imm        = im[7:0];
        addr       = ad[9:0];
    endtask

    task automatic send_word(input int f, input int op, input int subop, input int skip,
                             input int ra, input int rb, input int im, input int ad,
                             output int acc_cyc);
        int waited;
        bit done;
        waited  = 0;
        done    = 1'b0;
        acc_cyc = -1;
        set_fields(f, op, subop, skip, ra, rb, im, ad);
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                if (!ref_illegal(f, op)) begin
                    exp_q.push_back({ADDR_W'(m_addr), ref_word(f, op, subop, skip, ra, rb, im, ad)});
                    m_addr++;
                    m_legal++;
                end else begin
                    m_err = 1'b1;
                end
                acc_cyc = cyc;
                done    = 1'b1;
            end else if (waited >= 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected acceptance", waited);
                done = 1'b1;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start(input int base);
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        exp_q.delete();
        m_base  = base;
        m_addr  = base;
        m_legal = 0;
        m_err   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mem_we) break;
            if (waited >= 500) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: got %0d writes outstanding expected 0", exp_q.size());
                break;
            end
            waited++;
        end
        @(posedge clk);
        #1;
    endtask

    // Compare end-of-session status against the model (called after wait_idle).
    task automatic check_session(input string tag);
        int next;
        bit full;
        next = m_base + m_legal;
        full = (next > MAX_ADDR);
        @(negedge clk);
        check({tag, "_count"}, 32'(count), 32'(m_legal));
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'(full ? MAX_ADDR : next));
        check({tag, "_err"}, 32'(err_illegal), 32'(m_err));
        check({tag, "_state"}, 32'(state_o), full ? 32'd2 : 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), full ? 32'd0 : 32'd1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int a1;
        int a2;
        int rel;
        int base;
        int n;
        int f;
        int op;

        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_err", 32'(err_illegal), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First REG word, latency 1
        do_start(12'h010);
        send_word(0, 2, 3, 1, 9, 5, 0, 0, a1);
        check("lat_mem_we", 32'(mem_we), 32'd1);
        check("lat_mem_addr", 32'(mem_addr), 32'h010);
        check("lat_mem_wdata", 32'(mem_wdata), 32'h2759);
        wait_idle();
        check_session("reg");

        // IMM and JMP back to back
        do_start(12'h020);
        send_word(1, 4, 0, 0, 3, 0, 8'hA5, 0, a1);
        send_word(2, 9, 0, 0, 0, 0, 0, 10'h155, a2);
        check("b2b_accept_gap", 32'(a2 - a1), 32'd1);
        wait_idle();
        check_session("b2b");

        // Back-pressure: stall three cycles, then release
        do_start(12'h080);
        ready_mode = 2;
        send_word(0, 1, 2, 0, 4, 6, 0, 0, a1);
        set_fields(1, 5, 0, 0, 7, 0, 8'h3C, 0);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_mem_we", 32'(mem_we), 32'd1);
            @(posedge clk);
            #1;
        end
        ready_mode = 0;
        rel = cyc;
        send_word(1, 5, 0, 0, 7, 0, 8'h3C, 0, a2);
        check("release_accept_cycle", 32'(a2), 32'(rel));
        wait_idle();
        check_session("stall");

        // Illegal encodings, then clear by start
        do_start(12'h040);
        send_word(2, 10, 0, 0, 0, 0, 0, 10'h123, a1);
        send_word(0, 8, 1, 0, 1, 1, 0, 0, a2);
        repeat (3) @(posedge clk);
        #1;
        check("illegal_no_we", 32'(mem_we), 32'd0);
        wait_idle();
        check_session("illegal");
        do_start(12'h040);
        @(negedge clk);
        check("start_clears_err", 32'(err_illegal), 32'd0);
        @(posedge clk);
        #1;

        // Top of memory
        do_start(12'h3FE);
        send_word(2, 8, 0, 0, 0, 0, 0, 10'h3FF, a1);
        send_word(2, 8, 0, 0, 0, 0, 0, 10'h3FF, a2);
        wait_idle();
        check_session("full");
        set_fields(0, 1, 0, 0, 1, 1, 0, 0);
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 32'd0);
            check("full_state", 32'(state_o), 32'd2);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        do_start(12'h100);
        @(negedge clk);
        check("full_restart_state", 32'(state_o), 32'd1);
        check("full_restart_addr", 32'(mem_addr), 32'h100);
        check("full_restart_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;

        // Reset with a write pending
        do_start(12'h050);
        ready_mode = 2;
        send_word(1, 3, 0, 0, 2, 0, 8'h11, 0, a1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;
        @(negedge clk);
        check("rstp_mem_we", 32'(mem_we), 32'd0);
        check("rstp_state", 32'(state_o), 32'd0);
        check("rstp_mem_addr", 32'(mem_addr), 32'd0);
        check("rstp_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rstp_count", 32'(count), 32'd0);
        check("rstp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;

        // Randomized sessions
        for (int s = 0; s < 10; s++) begin
            base = (s % 3 == 0) ? MAX_ADDR - int'($urandom_range(0, 20)) : int'($urandom_range(0, MAX_ADDR - 64));
            do_start(base);
            ready_mode = 1;
            n = int'($urandom_range(10, 40));
            for (int i = 0; i < n; i++) begin
                if (m_base + m_legal > MAX_ADDR) break;
                f  = int'($urandom_range(0, 3));
                op = (f == 2 && $urandom_range(0, 1) == 1) ? 8 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 15));
                send_word(f, op, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 1023)), a1);
                if ($urandom_range(0, 4) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
            // Every fourth session is cut short by the next start.
            if (s % 4 != 3) begin
                wait_idle();
                check_session("rand");
            end
        end
        ready_mode = 0;
        do_start(0);
        wait_idle();
        check_session("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
